pipe_result_checker: RTL and testbench

PIPE_RESULT_CHECKER -- requirements
Module: pipe_result_checker

---
 rtl/pipe_chk_pkg.sv | 14 +
 rtl/pipe_chk_delay.sv | 49 ++++
 rtl/pipe_result_checker.sv | 134 +++++++++++++
 tb/tb_pipe_result_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_chk_pkg.sv
// Shared defaults and FSM state type for the pipelined result checker.
package pipe_chk_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int LATENCY_DEF = 3;
   localparam int CNT_W_DEF   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_chk_delay.sv
// Fixed-depth delay line carrying a valid bit and a data word; flush clears
// every valid bit (including the one being loaded) on the next edge.
module pipe_chk_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [DEPTH-1:0] valid_bits
);

   logic [WIDTH-1:0] data_reg  [DEPTH];
   logic             valid_reg [DEPTH];

   // Data needs no reset: it is only ever looked at alongside its valid bit.
   always_ff @(posedge clk) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
         data_reg[i] <= data_reg[i-1];
      end
      data_reg[0] <= in_data;

      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_reg[i] <= 1'b0;
         end
      end else begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            valid_reg[i] <= valid_reg[i-1];
         end
         valid_reg[0] <= in_valid;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_vbits
         assign valid_bits[gi] = valid_reg[gi];
      end
   endgenerate

   assign out_valid = valid_reg[DEPTH-1];
   assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/pipe_result_checker.sv
// Checks a pipelined DUT computing ((A+B)+(C-D))*D against a delayed reference.
// Optional macro PIPE_CHK_CAPTURE_EN adds first_exp/first_got capture outputs.
module pipe_result_checker
   import pipe_chk_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LATENCY = LATENCY_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] C,
   input  logic [DATA_W-1:0] D,
   input  logic [DATA_W-1:0] dut_f,
   output logic [CNT_W-1:0]  chk_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              mismatch,
   output logic              fail,
   output logic              busy
`ifdef PIPE_CHK_CAPTURE_EN
   ,
   output logic [DATA_W-1:0] first_exp,
   output logic [DATA_W-1:0] first_got
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0]  sum_ab, diff_cd, sum_all, exp_now;
   logic [DATA_W-1:0]  exp_dly;
   logic               cmp_valid, cmp_bad;
   logic [LATENCY-1:0] line_valid;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   chk_cnt_reg, err_cnt_reg;
   logic               mismatch_reg;

   // Every intermediate is held at DATA_W so the reference wraps like the DUT.
   always_comb begin
      sum_ab  = A + B;
      diff_cd = C - D;
      sum_all = sum_ab + diff_cd;
      exp_now = sum_all * D;
   end

   pipe_chk_delay #(
      .DEPTH (LATENCY),
      .WIDTH (DATA_W)
   ) u_delay (
      .clk        (clk),
      .rst        (rst),
      .flush      (clr),
      .in_valid   (in_valid),
      .in_data    (exp_now),
      .out_valid  (cmp_valid),
      .out_data   (exp_dly),
      .valid_bits (line_valid)
   );

   assign cmp_bad = cmp_valid && (exp_dly != dut_f);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (in_valid) state_next = ST_RUN;
         ST_RUN: begin
            if (cmp_bad) begin
               state_next = ST_FAIL;
            end else if (!busy && !in_valid) begin
               state_next = ST_IDLE;
            end
         end
         ST_FAIL: state_next = ST_FAIL;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      fail = (state_reg == ST_FAIL);
      busy = |line_valid;
   end

   // Comparison and counting continue in FAIL; only rst/clr stop them.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         chk_cnt_reg  <= '0;
         err_cnt_reg  <= '0;
         mismatch_reg <= 1'b0;
      end else begin
         mismatch_reg <= cmp_bad;
         if (cmp_valid && (chk_cnt_reg != CNT_MAX)) begin
            chk_cnt_reg <= chk_cnt_reg + CNT_W'(1);
         end
         if (cmp_bad && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_reg <= err_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign chk_cnt  = chk_cnt_reg;
   assign err_cnt  = err_cnt_reg;
   assign mismatch = mismatch_reg;

`ifdef PIPE_CHK_CAPTURE_EN
   logic [DATA_W-1:0] first_exp_reg, first_got_reg;

   // Leaving RUN for FAIL marks the first mismatch since rst/clr.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         first_exp_reg <= '0;
         first_got_reg <= '0;
      end else if (cmp_bad && (state_reg != ST_FAIL)) begin
         first_exp_reg <= exp_dly;
         first_got_reg <= dut_f;
      end
   end

   assign first_exp = first_exp_reg;
   assign first_got = first_got_reg;
`endif

endmodule

// File: tb/tb_pipe_result_checker.sv
// Self-checking bench for pipe_result_checker: table vectors, corner sequences
// and a long saturation run, all scored against a cycle-level model.
module tb_pipe_result_checker;
   import pipe_chk_pkg::*;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst, clr, in_valid;
   logic [7:0]  A, B, C, D, dut_f;
   logic [15:0] chk_cnt, err_cnt;
   logic        mismatch, fail, busy;
`ifdef PIPE_CHK_CAPTURE_EN
   logic [7:0]  first_exp, first_got;
`endif

   always #5 clk = ~clk;

   pipe_result_checker #(
      .DATA_W  (8),
      .LATENCY (LAT),
      .CNT_W   (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_valid (in_valid),
      .A        (A),
      .B        (B),
      .C        (C),
      .D        (D),
      .dut_f    (dut_f),
      .chk_cnt  (chk_cnt),
      .err_cnt  (err_cnt),
      .mismatch (mismatch),
      .fail     (fail),
      .busy     (busy)
`ifdef PIPE_CHK_CAPTURE_EN
      ,
      .first_exp (first_exp),
      .first_got (first_got)
`endif
   );

   typedef struct {
      int         due;
      logic [7:0] exp;
      logic [7:0] f;
      bit         bad;
   } sb_t;

   typedef struct {
      logic [7:0] a, b, c, d;
      logic [7:0] exp;
      bit         bad;
      int         gap;
   } vec_t;

   sb_t    sb[$];
   int     n_chk = 0;
   int     n_fail = 0;
   int     cyc = 0;

   int     m_chk = 0, m_err = 0;
   bit     m_mis = 0;
   state_t m_st = ST_IDLE;
   int     m_fexp = 0, m_fgot = 0;

   function automatic logic [7:0] model_exp(int a, int b, int c, int d);
      int s;
      s = (((a + b) % 256) + ((c - d + 256) % 256)) % 256;
      return 8'((s * d) % 256);
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
      end
   endtask

   // One clock cycle: drive, check outputs of the previous edge, advance model.
   task automatic step(input bit v, input logic [7:0] a, b, c, d,
                       input logic [7:0] f, input bit bad,
                       input bit do_clr, input bit do_rst, input bit do_chk);
      bit  busy_now, cmp;
      sb_t e;
      @(posedge clk);
      #1;
      rst      = do_rst;
      clr      = do_clr;
      in_valid = v;
      A = a; B = b; C = c; D = d;
      if (sb.size() > 0 && sb[0].due == cyc) dut_f = sb[0].f;
      else dut_f = 8'($urandom);
      @(negedge clk);
      busy_now = (sb.size() != 0);
      if (do_chk) begin
         check("chk_cnt", int'(chk_cnt), m_chk);
         check("err_cnt", int'(err_cnt), m_err);
         check("mismatch", int'(mismatch), int'(m_mis));
         check("fail", int'(fail), int'(m_st == ST_FAIL));
         check("busy", int'(busy), int'(busy_now));
         check("state", int'(dut.state_reg), int'(m_st));
`ifdef PIPE_CHK_CAPTURE_EN
         check("first_exp", int'(first_exp), m_fexp);
         check("first_got", int'(first_got), m_fgot);
`endif
      end
      cmp = (sb.size() > 0 && sb[0].due == cyc);
      if (cmp) e = sb.pop_front();
      if (do_rst || do_clr) begin
         sb.delete();
         m_chk = 0; m_err = 0; m_mis = 0; m_st = ST_IDLE;
         m_fexp = 0; m_fgot = 0;
      end else begin
         m_mis = cmp && e.bad;
         if (cmp && m_chk != 65535) m_chk++;
         if (m_mis && m_err != 65535) m_err++;
         if (m_mis && m_st != ST_FAIL) begin
            m_fexp = int'(e.exp);
            m_fgot = int'(e.f);
         end
         case (m_st)
            ST_IDLE: if (v) m_st = ST_RUN;
            ST_RUN:  if (m_mis) m_st = ST_FAIL;
                     else if (!busy_now && !v) m_st = ST_IDLE;
            default: ;
         endcase
         if (v) sb.push_back('{due: cyc + LAT, exp: model_exp(a, b, c, d), f: f, bad: bad});
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic rnd_valid(input bit do_chk);
      logic [7:0] a, b, c, d;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      step(1, a, b, c, d, model_exp(a, b, c, d), 0, 0, 0, do_chk);
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{8'd1,   8'd2,   8'd5,   8'd3,   8'd15,  0, 0};
      tbl[1]  = '{8'd200, 8'd100, 8'd10,  8'd20,  8'd168, 0, 0};
      tbl[2]  = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   0, 1};
      tbl[3]  = '{8'd255, 8'd1,   8'd3,   8'd2,   8'd2,   0, 0};
      tbl[4]  = '{8'd10,  8'd20,  8'd5,   8'd7,   8'd196, 0, 2};
      tbl[5]  = '{8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 0, 0};
      tbl[6]  = '{8'd127, 8'd127, 8'd100, 8'd50,  8'd96,  0, 0};
      tbl[7]  = '{8'd3,   8'd4,   8'd250, 8'd16,  8'd16,  0, 1};
      tbl[8]  = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd2,   0, 0};
      tbl[9]  = '{8'd200, 8'd100, 8'd10,  8'd20,  8'd168, 1, 1};
      tbl[10] = '{8'd50,  8'd60,  8'd70,  8'd80,  8'd64,  0, 0};
      tbl[11] = '{8'd1,   8'd2,   8'd5,   8'd3,   8'd15,  0, 0};

      rst = 1; clr = 0; in_valid = 0; A = 0; B = 0; C = 0; D = 0; dut_f = 0;
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(2);

      // Single correct transaction.
      step(1, 8'd1, 8'd2, 8'd5, 8'd3, 8'd15, 0, 0, 0, 1);
      idle(5);

      // Table vectors; entry 9 drives 169 where 168 is expected.
      foreach (tbl[i]) begin
         step(1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d,
              tbl[i].bad ? (tbl[i].exp ^ 8'h01) : tbl[i].exp, tbl[i].bad, 0, 0, 1);
         idle(tbl[i].gap);
      end
      idle(5);

      // clr together with in_valid while in FAIL: sample dropped.
      step(1, 8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 1, 1, 0, 1);
      idle(6);

      // Ten back-to-back valids, then bubbles until idle.
      for (int i = 0; i < 10; i++) rnd_valid(1);
      idle(6);

      // Reset with two entries in flight; later dut_f is junk.
      rnd_valid(1);
      rnd_valid(1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(6);

      // clr in RUN with entries in flight.
      rnd_valid(1);
      rnd_valid(1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      idle(6);

      // Saturation of chk_cnt.
      for (int i = 0; i < 65540; i++) rnd_valid((i % 8192) == 0 || i > 65530);
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
